// File: rtl/dsp48a1_op_driver.sv
// rtl/dsp48a1_op_driver.sv - operand launcher and in-order result buffer for a DSP48A1 slice
//
// Purpose:
//    Accepts operations on a valid/ready handshake and registers their operands onto the
//    DSP48A1 slice inputs. A valid shift register tracks each launched op through the slice
//    pipeline so that dsp_p can be captured LATENCY edges later. Captured results go into an
//    RBUF-entry FIFO and are presented in issue order. New ops are admitted only while a FIFO
//    slot is guaranteed for them, so the FIFO can never overflow.
//
// Ports:
//    clk, rst                   clock; asynchronous active-high reset
//    en, flush                  run enable; flush stops admission and drains to IDLE
//    in_valid/in_ready          operation handshake; in_a, in_b, in_c, in_opmode operands
//    dsp_a/b/c, dsp_opmode      registered operands to the slice (opmode is 0 when no op)
//    dsp_p                      slice result
//    out_valid/out_ready, out_p result handshake; out_p is the FIFO head
//    busy                       block not idle, or results still in flight or buffered
module dsp48a1_op_driver #(
   parameter int WIDTH   = 18,
   parameter int PWIDTH  = 48,
   parameter int LATENCY = 4,
   parameter int RBUF    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   input  logic [PWIDTH-1:0] in_c,
   input  logic [7:0]        in_opmode,
   output logic [WIDTH-1:0]  dsp_a,
   output logic [WIDTH-1:0]  dsp_b,
   output logic [PWIDTH-1:0] dsp_c,
   output logic [7:0]        dsp_opmode,
   input  logic [PWIDTH-1:0] dsp_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PWIDTH-1:0] out_p,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_t;

   // Counters hold up to 8 (LATENCY and RBUF are both at most 8).
   localparam int CNTW = 4;
   localparam int PTRW = $clog2(RBUF);
   localparam logic [PTRW-1:0] LAST_PTR = PTRW'(RBUF - 1);
   localparam logic [CNTW:0]   RBUF_W   = (CNTW + 1)'(RBUF);

   state_t              state_q, state_d;
   logic [LATENCY-1:0]  vsr_q, vsr_d;
   logic [CNTW-1:0]     inflight_q, inflight_d;
   logic [CNTW-1:0]     count_q, count_d;
   logic [PTRW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PWIDTH-1:0]   mem_q [RBUF];
   logic [PWIDTH-1:0]   mem_d [RBUF];
   logic [WIDTH-1:0]    dsp_a_q, dsp_a_d;
   logic [WIDTH-1:0]    dsp_b_q, dsp_b_d;
   logic [PWIDTH-1:0]   dsp_c_q, dsp_c_d;
   logic [7:0]          dsp_opmode_q, dsp_opmode_d;

   logic issue;
   logic push;
   logic pop;

   // Every in-flight op already owns a FIFO slot, so admission depends only on registered
   // counters; a slot freed by a pop becomes visible one cycle later.
   assign in_ready  = (state_q == ACTIVE) && (({1'b0, inflight_q} + {1'b0, count_q}) < RBUF_W);
   assign out_valid = (count_q != '0);
   assign out_p     = mem_q[rd_ptr_q];
   assign busy      = (state_q != IDLE) || (inflight_q != '0) || (count_q != '0);

   assign issue = in_valid && in_ready;
   assign push  = vsr_q[LATENCY-1];
   assign pop   = out_valid && out_ready;

   assign dsp_a      = dsp_a_q;
   assign dsp_b      = dsp_b_q;
   assign dsp_c      = dsp_c_q;
   assign dsp_opmode = dsp_opmode_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en && !flush) state_d = ACTIVE;
         ACTIVE:  if (flush || !en) state_d = FLUSH;
         FLUSH:   if ((inflight_q == '0) && (count_q == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      vsr_d = (vsr_q << 1) | LATENCY'(issue);

      // Data operands hold between ops; opmode returns to 0 so the slice idles.
      dsp_a_d      = issue ? in_a : dsp_a_q;
      dsp_b_d      = issue ? in_b : dsp_b_q;
      dsp_c_d      = issue ? in_c : dsp_c_q;
      dsp_opmode_d = issue ? in_opmode : 8'h00;

      inflight_d = inflight_q;
      if (issue && !push)      inflight_d = inflight_q + CNTW'(1);
      else if (!issue && push) inflight_d = inflight_q - CNTW'(1);

      count_d = count_q;
      if (push && !pop)      count_d = count_q + CNTW'(1);
      else if (!push && pop) count_d = count_q - CNTW'(1);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = dsp_p;
         wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTRW'(1);
      end

      rd_ptr_d = rd_ptr_q;
      if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTRW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         vsr_q        <= '0;
         inflight_q   <= '0;
         count_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         dsp_a_q      <= '0;
         dsp_b_q      <= '0;
         dsp_c_q      <= '0;
         dsp_opmode_q <= '0;
         for (int i = 0; i < RBUF; i++) mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         vsr_q        <= vsr_d;
         inflight_q   <= inflight_d;
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         dsp_a_q      <= dsp_a_d;
         dsp_b_q      <= dsp_b_d;
         dsp_c_q      <= dsp_c_d;
         dsp_opmode_q <= dsp_opmode_d;
         mem_q        <= mem_d;
      end
   end

endmodule

// File: tb/tb_dsp48a1_op_driver.sv
// tb/tb_dsp48a1_op_driver.sv - scoreboard bench for dsp48a1_op_driver
module tb_dsp48a1_op_driver;

   localparam int WIDTH  = 18;
   localparam int PWIDTH = 48;
   localparam int LAT    = 4;
   localparam int RBUF   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_a;
   logic [WIDTH-1:0]  in_b;
   logic [PWIDTH-1:0] in_c;
   logic [7:0]        in_opmode;
   logic [WIDTH-1:0]  dsp_a;
   logic [WIDTH-1:0]  dsp_b;
   logic [PWIDTH-1:0] dsp_c;
   logic [7:0]        dsp_opmode;
   logic [PWIDTH-1:0] dsp_p;
   logic              out_valid;
   logic              out_ready;
   logic [PWIDTH-1:0] out_p;
   logic              busy;

   dsp48a1_op_driver #(.WIDTH(WIDTH), .PWIDTH(PWIDTH), .LATENCY(LAT), .RBUF(RBUF)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_opmode(in_opmode),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
      .dsp_p(dsp_p),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Directed vectors; opmode bit 3 selects P = A*B + C, otherwise P = A*B.
   localparam logic [WIDTH-1:0]  VA [8] = '{18'd3, 18'd7, 18'd1000, 18'd0, 18'h3FFFF, 18'd12, 18'd1, 18'd100};
   localparam logic [WIDTH-1:0]  VB [8] = '{18'd5, 18'd9, 18'd2000, 18'd12345, 18'd2, 18'd12, 18'd1, 18'd100};
   localparam logic [PWIDTH-1:0] VC [8] = '{48'd0, 48'd100, 48'd5, 48'd77, 48'd0, 48'd1000000, 48'hFFFF_FFFF_FFFF, 48'd123};
   localparam logic [7:0]        VO [8] = '{8'h01, 8'h0D, 8'h0D, 8'h0D, 8'h01, 8'h0D, 8'h0D, 8'h01};
   localparam logic [PWIDTH-1:0] VE [8] = '{48'd15, 48'd163, 48'd2000005, 48'd77, 48'd524286, 48'd1000144, 48'd0, 48'd10000};

   // Slice model: result valid LAT edges after operand launch.
   logic [PWIDTH-1:0] p_comb;
   logic [PWIDTH-1:0] slice_pipe [LAT-1];
   always_comb p_comb = PWIDTH'(dsp_a) * PWIDTH'(dsp_b) + (dsp_opmode[3] ? dsp_c : '0);
   always @(posedge clk) begin
      slice_pipe[0] <= p_comb;
      for (int i = 1; i < LAT - 1; i++) slice_pipe[i] <= slice_pipe[i-1];
   end
   assign dsp_p = slice_pipe[LAT-2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   int vi = 0, acc_cnt = 0, acc_cyc = 0, pop_cnt = 0, last_pop_cyc = 0, ov_seen = 0;
   logic [PWIDTH-1:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Scoreboard: acceptances push expected results, DUT outputs pop and compare.
   initial begin
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            exp_q.delete();
         end else begin
            if (out_valid) ov_seen++;
            if (out_valid && out_ready) begin
               pop_cnt++;
               last_pop_cyc = cyc;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL spurious_out: got out_p=%0d, expected no result", out_p);
               end else begin
                  chk("out_p", out_p, exp_q.pop_front());
               end
            end
            if (in_valid && in_ready) begin
               exp_q.push_back(VE[vi % 8]);
               vi++;
               acc_cnt++;
               acc_cyc = cyc;
            end
         end
      end
   end

   task automatic load();
      in_a      = VA[vi % 8];
      in_b      = VB[vi % 8];
      in_c      = VC[vi % 8];
      in_opmode = VO[vi % 8];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      load();
   endtask

   task automatic run_issue(input int n, input int budget);
      int target;
      int k;
      tick();
      target   = acc_cnt + n;
      k        = 0;
      in_valid = 1'b1;
      while (acc_cnt < target && k < budget) begin
         tick();
         k++;
      end
      chk("issue_count", acc_cnt, target);
   endtask

   task automatic drain_q(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      chk("drain_results", exp_q.size(), 0);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (busy && k < budget) begin
         tick();
         k++;
      end
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_results", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a0, p0, o0, k;
      rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_c = '0; in_opmode = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dsp_opmode", dsp_opmode, 0);
      chk("rst_out_p", out_p, 0);
      @(posedge clk); #1; rst = 1'b0;

      // IDLE ignores in_valid until en is sampled.
      in_valid = 1'b1;
      a0 = acc_cnt;
      repeat (3) tick();
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_no_issue", acc_cnt - a0, 0);
      tick();
      in_valid = 1'b0;
      en = 1'b1;
      tick();
      @(negedge clk);
      chk("active_in_ready", in_ready, 1);

      // Single op: 3*5 = 15, out_valid LAT+1 cycles after the issue cycle.
      out_ready = 1'b1;
      run_issue(1, 10);
      in_valid = 1'b0;
      @(negedge clk);
      chk("launch_dsp_a", dsp_a, 3);
      chk("launch_dsp_b", dsp_b, 5);
      chk("launch_dsp_opmode", dsp_opmode, 8'h01);
      tick();
      @(negedge clk);
      chk("idle_dsp_opmode", dsp_opmode, 0);
      chk("hold_dsp_a", dsp_a, 3);
      drain_q(50);
      chk("latency", last_pop_cyc - acc_cyc, LAT + 1);
      @(negedge clk);
      chk("after_pop_valid", out_valid, 0);

      // Backpressure: RBUF ops admitted, then a single pop frees one slot a cycle later.
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a0 = acc_cnt;
      repeat (12) tick();
      @(negedge clk);
      chk("bp_accepted", acc_cnt - a0, RBUF);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_same_cycle", in_ready, 0);
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_ready_next_cycle", in_ready, 1);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain_q(100);

      // Streaming with out_ready held: each credit turns over every LAT+2 cycles.
      in_valid = 1'b1;
      repeat (15) tick();
      p0 = pop_cnt;
      repeat (24) tick();
      chk("stream_throughput", pop_cnt - p0, 16);
      in_valid = 1'b0;
      drain_q(100);

      // Flush asserted alongside a 4th valid op: op still accepted, then drain to IDLE.
      p0 = pop_cnt;
      run_issue(3, 20);
      flush = 1'b1;
      a0 = acc_cnt;
      @(negedge clk);
      chk("flush_4th_accept", acc_cnt - a0, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 0);
      chk("flush_busy", busy, 1);
      wait_idle(100);
      chk("flush_results", pop_cnt - p0, 4);
      tick();
      flush = 1'b0;

      // en dropped while in_valid stays high.
      tick();
      run_issue(2, 20);
      en = 1'b0;
      tick();
      @(negedge clk);
      chk("en_off_ready_1", in_ready, 0);
      tick();
      @(negedge clk);
      chk("en_off_ready_2", in_ready, 0);
      tick();
      in_valid = 1'b0;
      wait_idle(100);

      // Asynchronous reset with two ops in flight and one buffered.
      tick();
      en = 1'b1;
      out_ready = 1'b0;
      tick();
      run_issue(3, 20);
      in_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 20);
      chk("rst_setup_valid", out_valid, 1);
      #2;
      rst = 1'b1;
      en  = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_dsp_opmode", dsp_opmode, 0);
      chk("arst_dsp_a", dsp_a, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_out_p", out_p, 0);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      o0 = ov_seen;
      repeat (3) tick();
      @(negedge clk);
      chk("post_rst_idle_busy", busy, 0);
      chk("post_rst_idle_ready", in_ready, 0);
      tick();
      en = 1'b1;
      repeat (20) tick();
      @(negedge clk);
      chk("post_rst_no_results", ov_seen - o0, 0);
      chk("post_rst_active", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
